// File: rtl/core_c2_lsu_biu.sv
// C2 load/store bus interface unit: single issue register, in-order outstanding
// tracking with a load-metadata FIFO, store lane alignment and load formatting.
module core_c2_lsu_biu #(
  parameter int unsigned AW      = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  output logic          exu_pause,
  output logic          rsp_valid,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  output logic          sb_arvalid,
  input  logic          sb_arready,
  output logic [AW-1:0] sb_araddr,
  input  logic          sb_rvalid,
  output logic          sb_rready,
  input  logic [31:0]   sb_rdata,
  input  logic          sb_rresp,
  output logic          sb_wvalid,
  input  logic          sb_wready,
  output logic [AW-1:0] sb_waddr,
  output logic [31:0]   sb_wdata,
  output logic [3:0]    sb_wstrb,
  input  logic          sb_bvalid,
  output logic          sb_bready,
  input  logic          sb_bresp
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW:0]   MAX_OCC  = (CW + 1)'(MAX_OUT);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUT - 1);

  typedef enum logic {DIR_LOAD = 1'b0, DIR_STORE = 1'b1} dir_t;

  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       sgn;
  } meta_t;

  logic          hold_vld;
  dir_t          hold_dir;
  dir_t          odir;
  logic [AW-1:0] hold_addr;
  logic [31:0]   hold_data;
  logic [3:0]    hold_strb;
  logic [1:0]    hold_off;
  logic [1:0]    hold_size;
  logic          hold_sgn;
  logic [CW-1:0] cnt;
  logic [CW:0]   occ;

  meta_t         fifo [MAX_OUT];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  meta_t         head;

  logic ar_hs, w_hs, issue, busy, r_hs, b_hs;
  logic misal, idle, room, dir_ok, slot_free;
  logic accept, acc_bus, acc_err;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [31:0] sh;
  logic [31:0] ld_data;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign sb_arvalid = hold_vld & (hold_dir == DIR_LOAD);
  assign sb_wvalid  = hold_vld & (hold_dir == DIR_STORE);
  assign sb_araddr  = hold_addr;
  assign sb_waddr   = hold_addr;
  assign sb_wdata   = hold_data;
  assign sb_wstrb   = hold_strb;
  assign sb_rready  = 1'b1;
  assign sb_bready  = 1'b1;

  assign ar_hs = sb_arvalid & sb_arready;
  assign w_hs  = sb_wvalid & sb_wready;
  assign issue = ar_hs | w_hs;
  assign busy  = (cnt != '0);
  assign r_hs  = sb_rvalid & busy & (odir == DIR_LOAD);
  assign b_hs  = sb_bvalid & busy & (odir == DIR_STORE);

  assign misal = (req_size == 2'd3) ||
                 (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  // The held request counts towards the limit so that the bus side never has
  // more than MAX_OUT in flight, and direction is judged on bus plus holding
  // register so a firing request of the other kind cannot mix with a new one.
  assign occ       = {1'b0, cnt} + {{CW{1'b0}}, hold_vld};
  assign room      = (occ < MAX_OCC);
  assign idle      = ~busy & ~hold_vld;
  assign dir_ok    = idle | (odir == dir_t'(req_we));
  assign slot_free = ~hold_vld | issue;

  assign req_ready = slot_free & room & dir_ok & (~misal | idle);
  assign exu_pause = req_valid & ~req_ready;
  assign accept    = req_valid & req_ready;
  assign acc_bus   = accept & ~misal;
  assign acc_err   = accept & misal;

  always_comb begin
    st_data = req_wdata;
    st_strb = 4'hF;
    case (req_size)
      2'd0: begin
        st_data = {4{req_wdata[7:0]}};
        st_strb = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        st_data = {2{req_wdata[15:0]}};
        st_strb = req_addr[1] ? 4'hC : 4'h3;
      end
      default: ;
    endcase
  end

  assign head = fifo[rd_ptr];
  assign sh   = sb_rdata >> {head.off, 3'b000};

  always_comb begin
    ld_data = sh;
    case (head.size)
      2'd0:    ld_data = head.sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      2'd1:    ld_data = head.sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ar_hs) fifo[wr_ptr] <= '{off: hold_off, size: hold_size, sgn: hold_sgn};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold_dir  <= DIR_LOAD;
      odir      <= DIR_LOAD;
      hold_addr <= '0;
      hold_data <= '0;
      hold_strb <= '0;
      hold_off  <= '0;
      hold_size <= '0;
      hold_sgn  <= 1'b0;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (acc_bus) begin
        hold_vld  <= 1'b1;
        hold_dir  <= dir_t'(req_we);
        odir      <= dir_t'(req_we);
        hold_addr <= req_addr & ~(AW'(3));
        hold_data <= st_data;
        hold_strb <= st_strb;
        hold_off  <= req_addr[1:0];
        hold_size <= req_size;
        hold_sgn  <= req_signed;
      end else if (issue) begin
        hold_vld <= 1'b0;
      end

      case ({issue, r_hs | b_hs})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase

      if (ar_hs) wr_ptr <= ptr_next(wr_ptr);
      if (r_hs)  rd_ptr <= ptr_next(rd_ptr);

      rsp_valid <= r_hs | b_hs | acc_err;
      rsp_err   <= (r_hs & sb_rresp) | (b_hs & sb_bresp) | acc_err;
      rsp_data  <= (r_hs & ~sb_rresp) ? ld_data : '0;
    end
  end

endmodule

// File: tb/tb_core_c2_lsu_biu.sv
// Self-checking bench for core_c2_lsu_biu: scripted bus slave with a response
// scoreboard; each scenario task checks its own bus-side observations.
module tb_core_c2_lsu_biu;
  localparam int unsigned AW = 32;
  localparam int unsigned MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0] req_size = '0;
  logic exu_pause, rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic sb_arvalid, sb_arready = 1'b1, sb_rvalid = 1'b0, sb_rready, sb_rresp = 1'b0;
  logic [AW-1:0] sb_araddr, sb_waddr;
  logic [31:0] sb_rdata = '0, sb_wdata;
  logic sb_wvalid, sb_wready = 1'b1, sb_bvalid = 1'b0, sb_bready, sb_bresp = 1'b0;
  logic [3:0] sb_wstrb;

  core_c2_lsu_biu #(.AW(AW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed), .exu_pause(exu_pause),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sb_arvalid(sb_arvalid), .sb_arready(sb_arready), .sb_araddr(sb_araddr),
    .sb_rvalid(sb_rvalid), .sb_rready(sb_rready), .sb_rdata(sb_rdata), .sb_rresp(sb_rresp),
    .sb_wvalid(sb_wvalid), .sb_wready(sb_wready), .sb_waddr(sb_waddr),
    .sb_wdata(sb_wdata), .sb_wstrb(sb_wstrb),
    .sb_bvalid(sb_bvalid), .sb_bready(sb_bready), .sb_bresp(sb_bresp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;
  int unsigned ar_count = 0;

  always @(posedge clk) if (rst_n && sb_arvalid && sb_arready) ar_count <= ar_count + 1;

  // Response scoreboard: every rsp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected got data=%h err=%b required none", rsp_data, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (rsp_data !== mon_e.data) begin
          errors++; $display("FAIL rsp_data got %h required %h", rsp_data, mon_e.data);
        end
        checks++;
        if (rsp_err !== mon_e.err) begin
          errors++; $display("FAIL rsp_err got %b required %b", rsp_err, mon_e.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sg);
    int o;
    logic [7:0] b;
    logic [15:0] h;
    o = int'(off);
    if (sz == 2'd0) begin
      b = d[o*8 +: 8];
      return sg ? {{24{b[7]}}, b} : {24'h0, b};
    end else if (sz == 2'd1) begin
      h = off[1] ? d[31:16] : d[15:0];
      return sg ? {{16{h[15]}}, h} : {16'h0, h};
    end
    return d;
  endfunction

  task automatic expect_rsp(input logic e, input logic [31:0] d);
    exp_q.push_back({e, d});
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic sg);
    int n;
    n = 0;
    req_we = we; req_addr = a; req_wdata = d; req_size = sz; req_signed = sg;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout addr %h ready got 0 required 1", a);
    end
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic rbeat(input logic [31:0] d, input logic r);
    sb_rdata = d; sb_rresp = r; sb_rvalid = 1'b1;
    @(posedge clk); #1 sb_rvalid = 1'b0;
  endtask

  task automatic bbeat(input logic r);
    sb_bresp = r; sb_bvalid = 1'b1;
    @(posedge clk); #1 sb_bvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending got %0d required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", req_ready); end
    checks++; if (exu_pause !== 1'b0) begin errors++; $display("FAIL reset_pause got %b required 0", exu_pause); end
    checks++; if (sb_arvalid !== 1'b0 || sb_wvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b required 00", sb_arvalid, sb_wvalid); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b required 0", rsp_valid); end
    checks++; if (sb_araddr !== '0 || sb_wdata !== '0 || sb_wstrb !== '0) begin errors++; $display("FAIL reset_bus got %h %h %h required 0", sb_araddr, sb_wdata, sb_wstrb); end
    @(posedge clk); #1;
  endtask

  task automatic test_word_load();
    send(1'b0, 32'h1000, '0, 2'd2, 1'b0);
    @(negedge clk);
    checks++; if (sb_arvalid !== 1'b1) begin errors++; $display("FAIL wl_arvalid got %b required 1", sb_arvalid); end
    checks++; if (sb_araddr !== 32'h1000) begin errors++; $display("FAIL wl_araddr got %h required 00001000", sb_araddr); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (sb_arvalid !== 1'b0) begin errors++; $display("FAIL wl_arvalid_drop got %b required 0", sb_arvalid); end
    @(posedge clk); #1;
    expect_rsp(1'b0, 32'hDEADBEEF);
    rbeat(32'hDEADBEEF, 1'b0);
    wait_drain();
  endtask

  task automatic test_byte_load();
    for (int s = 1; s >= 0; s--) begin
      send(1'b0, 32'h1003, '0, 2'd0, s[0]);
      @(negedge clk);
      checks++; if (sb_araddr !== 32'h1000) begin errors++; $display("FAIL bl_araddr got %h required 00001000", sb_araddr); end
      @(posedge clk); #1;
      expect_rsp(1'b0, s[0] ? 32'hFFFFFF80 : 32'h00000080);
      rbeat(32'h80FFFFFF, 1'b0);
      wait_drain();
    end
  endtask

  task automatic test_format_random();
    logic [1:0] sz, off;
    logic sg;
    logic [31:0] d;
    for (int i = 0; i < 10; i++) begin
      sz = 2'($urandom_range(0, 2));
      off = (sz == 2'd0) ? 2'($urandom_range(0, 3)) : (sz == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
      sg = 1'($urandom_range(0, 1));
      d = $urandom;
      send(1'b0, 32'h7000 + 32'(i * 16) + 32'(off), '0, sz, sg);
      @(posedge clk); #1;
      if (i == 9) expect_rsp(1'b1, 32'h0);
      else expect_rsp(1'b0, fmt_load(d, off, sz, sg));
      rbeat(d, i == 9);
    end
    wait_drain();
  endtask

  task automatic test_half_store();
    send(1'b1, 32'h2002, 32'h0000ABCD, 2'd1, 1'b0);
    @(negedge clk);
    checks++; if (sb_wvalid !== 1'b1 || sb_arvalid !== 1'b0) begin errors++; $display("FAIL hs_valid got w%b ar%b required w1 ar0", sb_wvalid, sb_arvalid); end
    checks++; if (sb_waddr !== 32'h2000) begin errors++; $display("FAIL hs_waddr got %h required 00002000", sb_waddr); end
    checks++; if (sb_wstrb !== 4'hC) begin errors++; $display("FAIL hs_wstrb got %h required c", sb_wstrb); end
    checks++; if (sb_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL hs_wdata got %h required abcdabcd", sb_wdata); end
    @(posedge clk); #1;
    expect_rsp(1'b1, 32'h0);
    bbeat(1'b1);
    wait_drain();
    send(1'b1, 32'h2001, 32'h0000005A, 2'd0, 1'b0);
    @(negedge clk);
    checks++; if (sb_wstrb !== 4'h2) begin errors++; $display("FAIL bs_wstrb got %h required 2", sb_wstrb); end
    checks++; if (sb_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL bs_wdata got %h required 5a5a5a5a", sb_wdata); end
    @(posedge clk); #1;
    expect_rsp(1'b0, 32'h0);
    bbeat(1'b0);
    wait_drain();
  endtask

  task automatic test_outstanding();
    int unsigned base;
    base = ar_count;
    for (int i = 0; i < 4; i++) send(1'b0, 32'h4000 + 32'(i * 4), '0, 2'd2, 1'b0);
    req_we = 1'b0; req_addr = 32'h4010; req_size = 2'd2; req_signed = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0 || exu_pause !== 1'b1) begin errors++; $display("FAIL ol_pause got rdy%b pause%b required rdy0 pause1", req_ready, exu_pause); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0 || sb_arvalid !== 1'b0) begin errors++; $display("FAIL ol_hold got rdy%b ar%b required rdy0 ar0", req_ready, sb_arvalid); end
    checks++; if (ar_count - base !== 4) begin errors++; $display("FAIL ol_ar_count got %0d required 4", ar_count - base); end
    @(posedge clk); #1;
    expect_rsp(1'b0, 32'hA0000000);
    rbeat(32'hA0000000, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ol_slot_free got %b required 1", req_ready); end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (sb_arvalid !== 1'b1 || sb_araddr !== 32'h4010) begin errors++; $display("FAIL ol_fifth got ar%b %h required ar1 00004010", sb_arvalid, sb_araddr); end
    @(posedge clk); #1;
    for (int i = 1; i < 5; i++) begin
      expect_rsp(1'b0, 32'hA0000000 + 32'(i));
      rbeat(32'hA0000000 + 32'(i), 1'b0);
    end
    wait_drain();
    checks++; if (ar_count - base !== 5) begin errors++; $display("FAIL ol_ar_total got %0d required 5", ar_count - base); end
  endtask

  task automatic test_dir_switch();
    send(1'b0, 32'h5000, '0, 2'd2, 1'b0);
    send(1'b0, 32'h5004, '0, 2'd2, 1'b0);
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h5008; req_wdata = 32'h12345678; req_size = 2'd2; req_valid = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0 || exu_pause !== 1'b1) begin errors++; $display("FAIL ds_stall2 got rdy%b pause%b required rdy0 pause1", req_ready, exu_pause); end
    @(posedge clk); #1;
    expect_rsp(1'b0, 32'h0000_5000);
    rbeat(32'h0000_5000, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ds_stall1 got %b required 0", req_ready); end
    @(posedge clk); #1;
    expect_rsp(1'b0, 32'h0000_5004);
    rbeat(32'h0000_5004, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ds_release got %b required 1", req_ready); end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (sb_wvalid !== 1'b1 || sb_wdata !== 32'h12345678 || sb_wstrb !== 4'hF) begin errors++; $display("FAIL ds_store got w%b %h %h required w1 12345678 f", sb_wvalid, sb_wdata, sb_wstrb); end
    @(posedge clk); #1;
    expect_rsp(1'b0, 32'h0);
    bbeat(1'b0);
    wait_drain();
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [5] = '{32'h3001, 32'h3002, 32'h3001, 32'h3000, 32'h3003};
    logic [1:0]  sizes [5] = '{2'd2, 2'd2, 2'd1, 2'd3, 2'd1};
    logic        wes   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int unsigned base;
    for (int i = 0; i < 5; i++) begin
      base = ar_count;
      expect_rsp(1'b1, 32'h0);
      send(wes[i], addrs[i], 32'hFFFF_FFFF, sizes[i], 1'b0);
      @(negedge clk);
      checks++; if (sb_arvalid !== 1'b0 || sb_wvalid !== 1'b0) begin errors++; $display("FAIL ma_nobus_%0d got ar%b w%b required 00", i, sb_arvalid, sb_wvalid); end
      @(posedge clk); #1;
      checks++; if (ar_count !== base) begin errors++; $display("FAIL ma_ar_count_%0d got %0d required %0d", i, ar_count, base); end
    end
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) send(1'b0, 32'h6000 + 32'(i * 4), '0, 2'd2, 1'b0);
    @(posedge clk); #1;
    sb_arready = 1'b0;
    send(1'b0, 32'h600C, '0, 2'd2, 1'b0);
    @(negedge clk);
    checks++; if (sb_arvalid !== 1'b1) begin errors++; $display("FAIL rm_pending got %b required 1", sb_arvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sb_arvalid !== 1'b0 || sb_araddr !== '0) begin errors++; $display("FAIL rm_ar_clear got ar%b %h required 0 0", sb_arvalid, sb_araddr); end
    checks++; if (sb_wvalid !== 1'b0 || sb_wstrb !== '0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_out_clear got w%b %h rsp%b required 0", sb_wvalid, sb_wstrb, rsp_valid); end
    @(posedge clk); #1 rst_n = 1'b1; sb_arready = 1'b1;
    req_we = 1'b1; req_addr = 32'h6100; req_size = 2'd2; req_valid = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_cnt_zero got ready %b required 1", req_ready); end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rbeat(32'h0BAD0BAD, 1'b0);
    send(1'b0, 32'h6100, '0, 2'd2, 1'b0);
    @(posedge clk); #1;
    expect_rsp(1'b0, 32'h00000077);
    rbeat(32'h00000077, 1'b0);
    wait_drain();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_word_load();
    test_byte_load();
    test_format_random();
    test_half_store();
    test_outstanding();
    test_dir_switch();
    test_misaligned();
    test_reset_midflight();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue got %0d required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
